gpi_debounce: RTL and testbench
===============================

// Module: gpi_debounce
//
// PURPOSE
// Parametrised conditioning stage for board general-purpose inputs (switches, buttons).
// Sits between the FPGA top-level pins and gp_i of the demo system.
// Per channel it provides a multi-flop synchroniser, a consecutive-cycle debounce filter,
// single-cycle rise/fall pulses and a sticky, software-clearable edge-pending register.
// Replaces the direct pin-to-gp_i wiring, so channel count and filter depth now scale per board.
//
// PARAMETERS
// NumChan         8       number of independent input channels (>=1)
// SyncStages      2       synchroniser flops per channel (>=2)
// DebounceCycles  50000   consecutive cycles a new level must hold before acceptance (>=1)
// ResetVal        '0      NumChan-bit value of gp_o after reset
// CntW            $clog2(DebounceCycles+1)   derived counter width; not overridden
//
// PORTS
// clk_sys_i    in   1        system clock
// rst_sys_i    in   1        asynchronous, active-high reset
// gp_raw_i     in   NumChan  asynchronous pin inputs
// enable_i     in   1        filter enable; low freezes gp_o and clears counters
// pend_clr_i   in   NumChan  write-1-to-clear for pend_o, per bit
// gp_o         out  NumChan  debounced level
// rise_o       out  NumChan  1-cycle pulse when gp_o bit goes 0->1
// fall_o       out  NumChan  1-cycle pulse when gp_o bit goes 1->0
// pend_o       out  NumChan  sticky: set by any accepted edge on that channel
// any_pend_o   out  1        OR-reduction of pend_o (registered with pend_o, same cycle)
//
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - sync flops = ResetVal; gp_o = ResetVal
//   - counters, rise_o, fall_o, pend_o and any_pend_o = 0
// - Sync: s = last stage of the SyncStages-flop chain. The chain runs regardless of enable_i.
// - Per channel, every cycle with enable_i = 1:
//   - s == gp_o: counter <= 0 (a glitch shorter than DebounceCycles is discarded).
//   - s != gp_o and counter < DebounceCycles-1: counter <= counter+1.
//   - s != gp_o and counter == DebounceCycles-1:
//     - gp_o <= s; counter <= 0
//     - rise_o/fall_o pulse in the same cycle gp_o changes
// - Latency: raw change at edge 0, held stable.
//   - gp_o and the pulse are visible SyncStages + DebounceCycles cycles later.
//   - DebounceCycles = 1 gives SyncStages+1.
// - enable_i = 0: counters held at 0; gp_o frozen; no pulses.
//   - On re-enable, a full DebounceCycles window is required.
// - pend_o[i]: set on the cycle rise_o[i] or fall_o[i] is asserted; cleared by pend_clr_i[i].
//   - Simultaneous set and clear on the same bit: set wins.
// - Counter never exceeds DebounceCycles-1; no wrap.
// - Channels are fully independent; simultaneous edges on several channels all pulse.
// - Reset mid-filter: in-progress counts are lost.
//   - After release, an input differing from ResetVal needs a full window.
//   - It then produces a normal edge pulse and sets pend_o.
//
// TESTING (bench: NumChan=4, SyncStages=2, DebounceCycles=4, ResetVal=4'b0000)
// 1 After reset: gp_raw_i=4'b0001 held -> gp_o=0001 and rise_o=0001 exactly 6 cycles after
//   the raw edge; rise_o is 1 cycle wide; pend_o=0001; any_pend_o=1.
// 2 Glitch: bit1 high for 3 cycles, then low -> gp_o, rise_o and pend_o stay 0.
//   Bit1 held high for 4 cycles -> accepted.
// 3 Clear race: pend_clr_i=0001 on the same cycle as a new fall_o[0] -> pend_o[0] stays 1.
//   Next pend_clr_i=0001 with no edge -> 0.
// 4 enable_i=0, toggle all raw bits and hold -> no gp_o change and no pulses.
//   enable_i=1 -> gp_o updates 4 cycles later.
// 5 Simultaneous: raw 0000->1010 on one edge -> rise_o=1010 on a single cycle;
//   raw 1010->0000 -> fall_o=1010.
// 6 Assert rst_sys_i mid-count (counter=2) -> outputs return to reset values immediately
//   (async). Raw held high after release -> edge accepted 6 cycles after release.

Source files
------------

// File: rtl/gpi_debounce.sv
// Purpose: synchronise, debounce and edge-detect board general-purpose inputs, with a sticky pending flag per channel.
// Latency: a stable raw change reaches gp_o and rise_o/fall_o SyncStages + DebounceCycles cycles after the raw edge.
// Backpressure: none. Inputs are sampled every cycle; enable_i low freezes the filter but keeps the synchroniser running.
module gpi_debounce #(
    parameter int unsigned        NumChan        = 8,
    parameter int unsigned        SyncStages     = 2,
    parameter int unsigned        DebounceCycles = 50000,
    parameter logic [NumChan-1:0] ResetVal       = '0
) (
    input  logic               clk_sys_i,
    input  logic               rst_sys_i,
    input  logic [NumChan-1:0] gp_raw_i,
    input  logic               enable_i,
    input  logic [NumChan-1:0] pend_clr_i,
    output logic [NumChan-1:0] gp_o,
    output logic [NumChan-1:0] rise_o,
    output logic [NumChan-1:0] fall_o,
    output logic [NumChan-1:0] pend_o,
    output logic               any_pend_o
);

    // Counter only needs to reach DebounceCycles-1; acceptance happens on the
    // cycle the counter sits at that value, so it never wraps.
    localparam int unsigned       CntW   = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0]   CntMax = CntW'(DebounceCycles - 1);

    // Synchroniser chain: stage 0 samples the pins, last stage feeds the filter.
    logic [SyncStages-1:0][NumChan-1:0] sync_q;
    logic [NumChan-1:0]                 level_s;

    // Per-channel filter state and registered outputs.
    logic [NumChan-1:0][CntW-1:0] cnt_q;
    logic [NumChan-1:0][CntW-1:0] cnt_d;
    logic [NumChan-1:0]           accept;
    logic [NumChan-1:0]           gp_q;
    logic [NumChan-1:0]           gp_d;
    logic [NumChan-1:0]           rise_q;
    logic [NumChan-1:0]           rise_d;
    logic [NumChan-1:0]           fall_q;
    logic [NumChan-1:0]           fall_d;
    logic [NumChan-1:0]           pend_q;
    logic [NumChan-1:0]           pend_d;
    logic                         any_pend_q;

    // Shift the raw pins through the synchroniser; runs independently of enable_i.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            sync_q <= {SyncStages{ResetVal}};
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], gp_raw_i};
        end
    end

    assign level_s = sync_q[SyncStages-1];

    // Count consecutive cycles the synchronised level disagrees with gp_o;
    // any agreement or a disabled filter restarts the window from zero.
    always_comb begin
        cnt_d  = '0;
        accept = '0;
        for (int i = 0; i < NumChan; i++) begin
            if (enable_i && (level_s[i] != gp_q[i])) begin
                if (cnt_q[i] == CntMax) begin
                    accept[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // Next-state for level, edge pulses and the sticky pending flags.
    // Pending is set from the visible pulse, so a clear issued while the
    // pulse is on the output loses to the set.
    always_comb begin
        gp_d   = gp_q ^ accept;
        rise_d = accept & level_s;
        fall_d = accept & ~level_s;
        pend_d = (pend_q & ~pend_clr_i) | rise_q | fall_q;
    end

    // Filter counters.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Debounced level and single-cycle edge pulses.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            gp_q   <= ResetVal;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            gp_q   <= gp_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // Pending flags and their summary, registered together so they always agree.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            pend_q     <= '0;
            any_pend_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            any_pend_q <= |pend_d;
        end
    end

    assign gp_o       = gp_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign pend_o     = pend_q;
    assign any_pend_o = any_pend_q;

endmodule

// File: tb/tb_gpi_debounce.sv
// Purpose: self-checking bench for gpi_debounce with directed scenarios and randomized pin activity.
// Latency: checks against a window-based reference model every cycle on the falling clock edge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_gpi_debounce;

    localparam int NC   = 4;
    localparam int SS   = 2;
    localparam int DC   = 4;
    localparam logic [NC-1:0] RV = 4'b0000;
    localparam int MAXC = 8192;

    logic          clk;
    logic          rst;
    logic [NC-1:0] raw;
    logic          en;
    logic [NC-1:0] clr;
    logic [NC-1:0] gp;
    logic [NC-1:0] rise;
    logic [NC-1:0] fall;
    logic [NC-1:0] pend;
    logic          any_pend;

    int n_checks = 0;
    int n_errors = 0;

    gpi_debounce #(
        .NumChan        (NC),
        .SyncStages     (SS),
        .DebounceCycles (DC),
        .ResetVal       (RV)
    ) dut (
        .clk_sys_i  (clk),
        .rst_sys_i  (rst),
        .gp_raw_i   (raw),
        .enable_i   (en),
        .pend_clr_i (clr),
        .gp_o       (gp),
        .rise_o     (rise),
        .fall_o     (fall),
        .pend_o     (pend),
        .any_pend_o (any_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n falling edges, then step just past them to drive inputs.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: logs every sampled input and decides acceptance by
    // looking back over the last DC cycles of the delayed pin history.
    // ------------------------------------------------------------------
    logic [NC-1:0] raw_log [0:MAXC-1];
    bit            en_log  [0:MAXC-1];
    int            cyc      = 0;
    int            last_rst = 0;
    int            last_evt [NC];
    logic [NC-1:0] m_gp   = RV;
    logic [NC-1:0] m_rise = '0;
    logic [NC-1:0] m_fall = '0;
    logic [NC-1:0] m_pend = '0;
    logic          m_any  = 1'b0;

    initial for (int c = 0; c < NC; c++) last_evt[c] = 0;

    // Level the filter sees at edge t: the pin value sampled SS edges earlier,
    // or the reset value if that sample predates the latest reset.
    function automatic bit s_at(input int t, input int c);
        if (t - SS > last_rst) return raw_log[t - SS][c];
        return RV[c];
    endfunction

    always @(posedge clk) begin
        logic [NC-1:0] nr;
        logic [NC-1:0] nf;
        bit            acc;
        cyc++;
        if (cyc < MAXC) begin
            raw_log[cyc] = raw;
            en_log[cyc]  = en;
        end
        if (rst) begin
            last_rst = cyc;
            for (int c = 0; c < NC; c++) last_evt[c] = cyc;
            m_gp = RV; m_rise = '0; m_fall = '0; m_pend = '0; m_any = 1'b0;
        end else begin
            m_pend = (m_pend & ~clr) | m_rise | m_fall;
            m_any  = |m_pend;
            nr = '0;
            nf = '0;
            for (int c = 0; c < NC; c++) begin
                // Accept only if the full window lies after the last event and
                // every cycle in it was enabled and disagreed with the level.
                acc = (cyc - DC + 1 > last_evt[c]);
                for (int k = 0; k < DC; k++) begin
                    if (acc && (!en_log[cyc - k] || s_at(cyc - k, c) == m_gp[c])) acc = 0;
                end
                if (acc) begin
                    nr[c] = s_at(cyc, c);
                    nf[c] = ~s_at(cyc, c);
                    m_gp[c] = ~m_gp[c];
                    last_evt[c] = cyc;
                end
            end
            m_rise = nr;
            m_fall = nf;
        end
    end

    // Compare every output against the model each cycle, away from the active edge.
    always @(negedge clk) begin
        chk("gp",       32'(gp),       32'(m_gp));
        chk("rise",     32'(rise),     32'(m_rise));
        chk("fall",     32'(fall),     32'(m_fall));
        chk("pend",     32'(pend),     32'(m_pend));
        chk("any_pend", 32'(any_pend), 32'(m_any));
    end

    // ------------------------------------------------------------------
    // Stimulus: directed scenarios, then randomized pin activity.
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        raw = '0;
        en  = 1'b1;
        clr = '0;
        tick(3);
        chk("rst_gp",   32'(gp),       32'(RV));
        chk("rst_rise", 32'(rise),     32'h0);
        chk("rst_pend", 32'(pend),     32'h0);
        chk("rst_any",  32'(any_pend), 32'h0);
        rst = 1'b0;
        tick(3);

        // Single rising input: level and pulse exactly SS+DC edges later.
        raw = 4'b0001;
        tick(5);
        chk("t1_gp_early", 32'(gp), 32'h0);
        tick(1);
        chk("t1_gp",   32'(gp),   32'h1);
        chk("t1_rise", 32'(rise), 32'h1);
        tick(1);
        chk("t1_rise_width", 32'(rise),     32'h0);
        chk("t1_pend",       32'(pend),     32'h1);
        chk("t1_any",        32'(any_pend), 32'h1);

        // Glitch of DC-1 cycles is discarded; DC cycles is accepted.
        raw = 4'b0011;
        tick(3);
        raw = 4'b0001;
        tick(8);
        chk("t2_glitch_gp",   32'(gp),   32'h1);
        chk("t2_glitch_pend", 32'(pend), 32'h1);
        raw = 4'b0011;
        tick(6);
        chk("t2_accept_gp", 32'(gp), 32'h3);
        tick(2);

        // Clear issued while the fall pulse is visible loses to the set.
        raw = 4'b0010;
        tick(6);
        chk("t3_fall", 32'(fall), 32'h1);
        clr = 4'b0001;
        tick(1);
        clr = '0;
        chk("t3_race_pend0", 32'(pend[0]), 32'h1);
        tick(1);
        clr = 4'b0001;
        tick(1);
        clr = '0;
        chk("t3_clear_pend0", 32'(pend[0]), 32'h0);

        // Disabled filter ignores a held change; re-enable needs a full window.
        en  = 1'b0;
        raw = 4'b1101;
        tick(20);
        chk("t4_frozen_gp", 32'(gp), 32'h2);
        en = 1'b1;
        tick(3);
        chk("t4_reen_early", 32'(gp), 32'h2);
        tick(1);
        chk("t4_reen_gp", 32'(gp), 32'hd);

        // Simultaneous edges on several channels pulse together.
        raw = 4'b0000;
        tick(10);
        clr = 4'b1111;
        tick(1);
        clr = '0;
        raw = 4'b1010;
        tick(5);
        chk("t5_rise_early", 32'(rise), 32'h0);
        tick(1);
        chk("t5_rise", 32'(rise), 32'ha);
        tick(1);
        chk("t5_rise_width", 32'(rise), 32'h0);
        raw = 4'b0000;
        tick(6);
        chk("t5_fall", 32'(fall), 32'ha);

        // Reset mid-count: asynchronous return to reset values, full window after release.
        raw = 4'b0101;
        tick(8);
        chk("t6_pre_gp", 32'(gp), 32'h5);
        raw = 4'b1111;
        tick(4);
        rst = 1'b1;
        #1;
        chk("t6_async_gp",   32'(gp),       32'(RV));
        chk("t6_async_pend", 32'(pend),     32'h0);
        chk("t6_async_any",  32'(any_pend), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(5);
        chk("t6_rel_early", 32'(gp), 32'h0);
        tick(1);
        chk("t6_rel_gp",   32'(gp),   32'hf);
        chk("t6_rel_rise", 32'(rise), 32'hf);
        tick(1);
        chk("t6_rel_pend", 32'(pend), 32'hf);

        // Randomized pin toggling, enable bursts, clears and occasional resets.
        for (int n = 0; n < 2500; n++) begin
            tick(1);
            if ($urandom_range(0, 5) == 0) begin
                int b;
                b = $urandom_range(0, NC - 1);
                raw[b] = ~raw[b];
            end
            if ($urandom_range(0, 49) == 0) en = ~en;
            clr = ($urandom_range(0, 7) == 0) ? NC'($urandom) : '0;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 399) == 0) rst = 1'b1;
        end
        rst = 1'b0;
        tick(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
